// File: rtl/lcd_char_writer.sv
// lcd_char_writer: buffers an upstream character stream in a FIFO, powers up
// and initialises an HD44780-class 8-bit LCD, then writes each character with
// correct RS/E timing. After 16 characters the cursor moves to line 2, and
// after 32 characters it returns to line 1.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   data, wen         : upstream character and its write strobe
//   full, overflow    : FIFO full; sticky flag for a write that arrived while full
//   init_done         : LCD initialisation finished
//   lcd_data, lcd_rs,
//   lcd_rw, lcd_e     : LCD bus (lcd_rw is always 0)
module lcd_char_writer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned E_PULSE    = 12,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLR_WAIT   = 82000,
  parameter int unsigned PWR_WAIT   = 750000,
  parameter int unsigned LINE_LEN   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       wen,
  output logic       full,
  output logic       overflow,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_A   = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int unsigned MAX_B   = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
  localparam int unsigned MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int unsigned MAX_CNT = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam int unsigned PW      = $clog2(2 * LINE_LEN + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(E_PULSE - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_WAIT - 1);
  localparam logic [CW-1:0] PWR_LAST   = CW'(PWR_WAIT - 1);
  localparam logic [PW-1:0] LINE_POS   = PW'(LINE_LEN);
  localparam logic [PW-1:0] WRAP_POS   = PW'(2 * LINE_LEN);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {PWR, INIT, IDLE, CHAR, ADDR} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, WAIT} phase_t;

  // ---------------- character FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          push, pop, empty;

  assign empty = (count == '0);
  // A pop in the same cycle frees the slot, so a write while full is accepted.
  assign push  = wen && (!full || pop);

  always_comb begin
    count_n = count;
    if (push && !pop)
      count_n = count + (AW + 1)'(1);
    else if (pop && !push)
      count_n = count - (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == FULL_CNT);
      if (wen && !push)
        overflow <= 1'b1;
    end
  end

  // ---------------- LCD sequencer ----------------
  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n, wait_last;
  logic [1:0]    idx, idx_n;
  logic [PW-1:0] pos, pos_n, pos_inc;
  logic [7:0]    data_n;
  logic          rs_n, e_n, done_n;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PWR;
      phase     <= SETUP;
      cnt       <= '0;
      idx       <= '0;
      pos       <= '0;
      lcd_data  <= '0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      pos       <= pos_n;
      lcd_data  <= data_n;
      lcd_rs    <= rs_n;
      lcd_e     <= e_n;
      init_done <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    cnt_n     = cnt + CW'(1);
    idx_n     = idx;
    pos_n     = pos;
    data_n    = lcd_data;
    rs_n      = lcd_rs;
    e_n       = lcd_e;
    done_n    = init_done;
    pop       = 1'b0;
    // Only the clear-display command needs the long settle time.
    wait_last = (!lcd_rs && lcd_data == 8'h01) ? CLR_LAST : CMD_LAST;
    pos_inc   = pos + PW'(1);

    unique case (state)
      PWR: begin
        if (cnt == PWR_LAST) begin
          state_n = INIT;
          phase_n = SETUP;
          cnt_n   = '0;
          idx_n   = '0;
          data_n  = init_cmd(2'd0);
          rs_n    = 1'b0;
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_n = CHAR;
          phase_n = SETUP;
          data_n  = mem[rd_ptr];
          rs_n    = 1'b1;
        end
      end
      default: begin
        // INIT, CHAR and ADDR all run the same SETUP/PULSE/WAIT write cycle.
        unique case (phase)
          SETUP: begin
            if (cnt == SETUP_LAST) begin
              phase_n = PULSE;
              cnt_n   = '0;
              e_n     = 1'b1;
            end
          end
          PULSE: begin
            if (cnt == PULSE_LAST) begin
              phase_n = WAIT;
              cnt_n   = '0;
              e_n     = 1'b0;
            end
          end
          default: begin
            if (cnt == wait_last) begin
              phase_n = SETUP;
              cnt_n   = '0;
              case (state)
                INIT: begin
                  if (idx == 2'd3) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    pos_n   = '0;
                  end else begin
                    idx_n  = idx + 2'd1;
                    data_n = init_cmd(idx + 2'd1);
                  end
                end
                CHAR: begin
                  if (pos_inc == LINE_POS) begin
                    state_n = ADDR;
                    pos_n   = pos_inc;
                    data_n  = 8'hC0;
                    rs_n    = 1'b0;
                  end else if (pos_inc == WRAP_POS) begin
                    state_n = ADDR;
                    pos_n   = '0;
                    data_n  = 8'h80;
                    rs_n    = 1'b0;
                  end else begin
                    state_n = IDLE;
                    pos_n   = pos_inc;
                  end
                end
                default: state_n = IDLE;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Testbench for lcd_char_writer: a scoreboard queue of expected LCD writes is
// filled by the stimulus from a behavioural display model; a monitor pops and
// compares on every rising edge of lcd_e and checks the strobe timing.
module tb_lcd_char_writer;
  localparam int FIFO_DEPTH = 16;
  localparam int SETUP_CYC  = 2;
  localparam int E_PULSE    = 3;
  localparam int CMD_WAIT   = 8;
  localparam int CLR_WAIT   = 16;
  localparam int PWR_WAIT   = 20;
  localparam int LINE_LEN   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       wen;
  logic       full, overflow, init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e;

  lcd_char_writer #(
    .FIFO_DEPTH(FIFO_DEPTH), .SETUP_CYC(SETUP_CYC), .E_PULSE(E_PULSE),
    .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT), .PWR_WAIT(PWR_WAIT), .LINE_LEN(LINE_LEN)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .wen(wen),
    .full(full), .overflow(overflow), .init_done(init_done),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural display model ----------------
  logic [8:0] exp_q[$];
  int         model_pos;
  int         pend_chars;
  int         char_rises[$];

  task automatic model_reset();
    exp_q.delete();
    pend_chars = 0;
    model_pos  = 0;
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  // Cursor moves to line 2 after 16 characters, back to line 1 after 32.
  task automatic model_char(input logic [7:0] b);
    exp_q.push_back({1'b1, b});
    pend_chars++;
    model_pos++;
    if (model_pos == LINE_LEN)
      exp_q.push_back({1'b0, 8'hC0});
    else if (model_pos == 2 * LINE_LEN) begin
      exp_q.push_back({1'b0, 8'h80});
      model_pos = 0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       e_prev = 1'b0, idone_prev = 1'b0, have_fall = 1'b0, stable = 1'b1;
    logic [8:0] rise_val = '0, expv;
    int         pulse_len = 0, fall_cyc = 0, prev_wait = 0, writes = 0, rst_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        e_prev = 1'b0; idone_prev = 1'b0; have_fall = 1'b0;
        writes = 0; pulse_len = 0; rst_cyc = cyc + 1;
      end else begin
        if (lcd_e && !e_prev) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: actual rs=%0d data=%02h required none", lcd_rs, lcd_data);
          end else begin
            expv = exp_q.pop_front();
            check("lcd_write", {23'd0, lcd_rs, lcd_data}, {23'd0, expv});
            if (expv[8]) pend_chars--;
          end
          check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
          if (have_fall) begin
            if (!lcd_rs)
              check("cmd_gap", cyc - fall_cyc, prev_wait + SETUP_CYC);
            else
              check("char_gap_min", {31'd0, (cyc - fall_cyc) >= prev_wait + SETUP_CYC + 1}, 32'd1);
          end else if (writes == 0) begin
            check("first_e_delay", {31'd0, (cyc - rst_cyc) >= PWR_WAIT + SETUP_CYC &&
                                           (cyc - rst_cyc) <= PWR_WAIT + SETUP_CYC + 1}, 32'd1);
          end
          if (lcd_rs) char_rises.push_back(cyc);
          rise_val = {lcd_rs, lcd_data};
          stable = 1'b1;
          pulse_len = 1;
          writes++;
        end else if (lcd_e) begin
          pulse_len++;
          if ({lcd_rs, lcd_data} !== rise_val) stable = 1'b0;
        end else if (e_prev) begin
          check("e_pulse_width", pulse_len, E_PULSE);
          check("data_stable_in_pulse", {31'd0, stable}, 32'd1);
          fall_cyc = cyc;
          have_fall = 1'b1;
          prev_wait = (rise_val == 9'h001) ? CLR_WAIT : CMD_WAIT;
        end
        if (have_fall && !lcd_e && {lcd_rs, lcd_data} !== rise_val && writes > 0 && rise_val[8] == 1'b0
            && cyc - fall_cyc < prev_wait)
          check("data_hold_in_wait", {23'd0, lcd_rs, lcd_data}, {23'd0, rise_val});
        if (init_done && !idone_prev) begin
          check("init_done_after_writes", writes, 4);
          check("init_done_timing", cyc - fall_cyc, CMD_WAIT);
        end
        if (!init_done && idone_prev)
          check("init_done_sticky", {31'd0, init_done}, 32'd1);
        e_prev = lcd_e;
        idone_prev = init_done;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] burst [13] = '{8'h5A, 8'h41, 8'h47, 8'h20, 8'h53, 8'h59, 8'h53,
                             8'h54, 8'h45, 8'h4D, 8'h53, 8'h20, 8'h20};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [7:0] b);
    wen = 1'b1;
    data = b;
    step();
    wen = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    check({"drain_", name}, exp_q.size(), 0);
    repeat (40) step();
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 500) begin step(); n++; end
    check({"init_wait_", name}, {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int         n, guard;
    logic       found;
    reset = 1'b1; wen = 1'b0; data = '0;

    // Power-up with no input
    do_reset(3);
    wait_drain("powerup", 2000);
    check("powerup_init_done", {31'd0, init_done}, 32'd1);

    // 13-byte burst during PWR
    do_reset(2);
    char_rises.delete();
    for (int i = 0; i < 13; i++) begin
      model_char(burst[i]);
      send(burst[i]);
      check("burst_full", {31'd0, full}, 32'd0);
    end
    check("burst_overflow", {31'd0, overflow}, 32'd0);
    wait_drain("burst", 3000);
    check("burst_count", char_rises.size(), 13);
    for (int i = 1; i < char_rises.size(); i++)
      check("burst_spacing", char_rises[i] - char_rises[i-1], 14);
    check("burst_overflow_end", {31'd0, overflow}, 32'd0);

    // 17 writes before init: 17th dropped, overflow sticky
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(32, 126));
      model_char(b);
      send(b);
    end
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_overflow", {31'd0, overflow}, 32'd0);
    send(8'h7E);
    check("drop_full", {31'd0, full}, 32'd1);
    check("drop_overflow", {31'd0, overflow}, 32'd1);
    wait_drain("overflow", 3000);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    check("drained_full", {31'd0, full}, 32'd0);

    // Full FIFO, write coinciding with the first IDLE pop
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(32, 126));
      model_char(b);
      send(b);
    end
    wait_init("full_pop");
    b = 8'($urandom_range(32, 126));
    model_char(b);
    send(b);
    check("pop_wen_overflow", {31'd0, overflow}, 32'd0);
    check("pop_wen_full", {31'd0, full}, 32'd1);
    wait_drain("full_pop", 3000);
    check("pop_wen_overflow_end", {31'd0, overflow}, 32'd0);

    // 33+ random characters after init, exercising both line wraps
    do_reset(2);
    wait_init("chars");
    n = 33 + int'($urandom_range(0, 8));
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (pend_chars >= FIFO_DEPTH && guard < 2000) begin step(); guard++; end
      repeat ($urandom_range(0, 3)) step();
      b = 8'($urandom_range(32, 126));
      model_char(b);
      send(b);
    end
    wait_drain("chars", 5000);
    check("chars_overflow", {31'd0, overflow}, 32'd0);

    // Reset during a character strobe: queued bytes are discarded
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(32, 126));
      model_char(b);
      send(b);
    end
    n = 0;
    found = 1'b0;
    while (!found && n < 300) begin
      if (lcd_e && lcd_rs) found = 1'b1;
      else begin step(); n++; end
    end
    check("reset_target_found", {31'd0, found}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_outputs", {19'd0, lcd_e, lcd_rs, lcd_data, init_done, full, overflow}, 32'd0);
    model_reset();
    wait_drain("after_reset", 2000);
    repeat (100) step();
    check("reinit_done", {31'd0, init_done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_char_writer.md
Name: lcd_char_writer

Overview:
- Downstream consumer of the character sequencer's data/wen stream (e.g. the 13-character "ZAG SYSTEMS  " burst, one byte per cycle).
- Buffers characters in a FIFO, then powers up and initialises an HD44780-class 8-bit parallel LCD.
- Writes each character to the LCD with correct RS/E timing, and manages cursor wrap between line 1 and line 2.

Parameters:
FIFO_DEPTH, 16, character FIFO entries (power of 2, >=16 so a full burst is absorbed)
SETUP_CYC, 2, cycles RS/data are stable before E rises
E_PULSE, 12, cycles E is held high
CMD_WAIT, 2000, cycles after E falls for normal command/char (40 us @50 MHz)
CLR_WAIT, 82000, cycles after E falls for clear-display 0x01
PWR_WAIT, 750000, cycles after reset before first init command
LINE_LEN, 16, characters per LCD line

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
data  in  8  ASCII character from upstream sequencer
wen  in  1  write strobe; data is valid in this cycle
full  out  1  FIFO full
overflow  out  1  sticky: a wen arrived while full
init_done  out  1  LCD init sequence complete
lcd_data  out  8  LCD DB[7:0]
lcd_rs  out  1  0 = command, 1 = character
lcd_rw  out  1  tied 0 (write-only)
lcd_e  out  1  LCD enable strobe

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0; FIFO empty; cursor pos = 0; FSM = PWR.
- Reset mid-operation aborts the current strobe: lcd_e drops on the next edge, FIFO contents are discarded, and init restarts.
- FIFO write: push on wen && !full, one entry per cycle, with no wait on the upstream.
- wen && full: byte dropped, overflow set; overflow stays set until reset.
- Write and pop in the same cycle when full is legal: the pop frees a slot and the write is accepted.
- full and the count are registered, updated on the edge after the push/pop.
- Write cycle, common to commands and characters:
  - SETUP: drive lcd_rs/lcd_data, lcd_e = 0, for SETUP_CYC cycles.
  - PULSE: lcd_e = 1 for E_PULSE cycles.
  - WAIT: lcd_e = 0 for CMD_WAIT cycles, or CLR_WAIT when the byte was 0x01.
  - lcd_data and lcd_rs hold their value through WAIT.
- States: PWR, INIT, IDLE, CHAR, ADDR, each using the write cycle above.
  - PWR: count PWR_WAIT cycles, then go to INIT.
  - INIT: issue 0x38, 0x0C, 0x01, 0x06 in order with rs = 0. After the last WAIT, set init_done = 1 (stays 1 until reset), clear pos to 0, go to IDLE.
  - IDLE: if the FIFO is non-empty, pop the head (same cycle) and go to CHAR. The popped byte appears on lcd_data on the next edge with rs = 1.
  - CHAR completion: pos increments.
    - new pos == LINE_LEN: go to ADDR with 0xC0.
    - new pos == 2*LINE_LEN: set pos = 0, go to ADDR with 0x80.
    - otherwise: go to IDLE.
  - ADDR: one command write cycle (rs = 0), then IDLE.
- Characters arriving during PWR/INIT are buffered, not lost (up to FIFO_DEPTH).
- A character pop occurs no sooner than the cycle after the previous WAIT ends. Back-to-back character period = SETUP_CYC + E_PULSE + CMD_WAIT + 1 cycles.
- lcd_rw is constant 0.

Test Plan (sim with PWR_WAIT=20, CMD_WAIT=8, CLR_WAIT=16, E_PULSE=3, SETUP_CYC=2):
- Power-up, no input:
  - lcd_e stays low for 20 cycles.
  - Then four E pulses with rs = 0 carrying 0x38, 0x0C, 0x01, 0x06; the WAIT after 0x01 is 16 cycles.
  - init_done rises after the last WAIT.
- 13-byte burst (0x5A,0x41,0x47,0x20,0x53,0x59,0x53,0x54,0x45,0x4D,0x53,0x20,0x20) on consecutive cycles during PWR:
  - full never asserts and overflow stays 0.
  - After init, exactly 13 rs = 1 pulses carry those bytes in order, 14 cycles apart.
- 17 back-to-back writes before init_done: bytes 1-16 stored and full = 1, byte 17 dropped, overflow = 1 and still 1 after the FIFO drains.
- 33 characters after init:
  - An 0xC0 command pulse follows the 16th character.
  - An 0x80 command pulse follows the 32nd character.
  - The 33rd character is written with pos = 0.
- Reset asserted for 1 cycle while lcd_e = 1 during a character write:
  - Next edge: lcd_e = 0, all outputs 0, init_done = 0.
  - Previously queued bytes are never written.
  - The full init sequence repeats.
- FIFO full, pop in IDLE with simultaneous wen: the new byte is accepted, overflow stays 0, and count stays FIFO_DEPTH.
